// File: rtl/tag_nios_ram_pkg.sv
// ---------------------------------------------------------------------------
// tag_nios_ram_pkg
// Shared definitions for the dual-port on-chip RAM family.
//   ramState_e       : shared access FSM states (zero-fill, then ready)
//   LAT_UNREG/LAT_REG: the two read latencies the RAM can be built with
//   clog2            : ceiling log2 used for index widths and parameter checks
// ---------------------------------------------------------------------------
package tag_nios_ram_pkg;

  // Both slave ports share one FSM: a zero-fill phase after reset, then
  // normal service.
  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } ramState_e;

  // Read latency 1 returns straight from the RAM output register; latency 2
  // adds one more register on the way out for timing closure.
  localparam int LAT_UNREG = 1;
  localparam int LAT_REG   = 2;

  // Ceiling log2, evaluated at elaboration time. clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tag_nios_dp_ram_core.sv
// ---------------------------------------------------------------------------
// tag_nios_dp_ram_core
// Behavioural true-dual-port, single-clock, byte-enabled RAM array.
// Each side has one write port and one registered read port with old-data
// semantics. When both sides write the same word, bytes enabled on side 1
// take side 1's data; bytes enabled on one side only take that side's data.
// Addresses at or beyond DEPTH never write, and read back as zero.
//
// Ports (N = 1, 2):
//   clk, reset   : system clock, synchronous active-high reset (read regs)
//   i_weN        : write this cycle
//   i_reN        : capture a read this cycle
//   i_addrN      : word address
//   i_beN        : byte lanes to write
//   i_wdataN     : write data
//   o_rdataN     : registered read data, held while i_reN is low
// ---------------------------------------------------------------------------
module tag_nios_dp_ram_core
  import tag_nios_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 13312,
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we1,
  input  logic                  i_re1,
  input  logic [ADDR_W-1:0]     i_addr1,
  input  logic [DATA_W/8-1:0]   i_be1,
  input  logic [DATA_W-1:0]     i_wdata1,
  output logic [DATA_W-1:0]     o_rdata1,
  input  logic                  i_we2,
  input  logic                  i_re2,
  input  logic [ADDR_W-1:0]     i_addr2,
  input  logic [DATA_W/8-1:0]   i_be2,
  input  logic [DATA_W-1:0]     i_wdata2,
  output logic [DATA_W-1:0]     o_rdata2
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              w_inRange1;
  logic              w_inRange2;
  logic [IDX_W-1:0]  w_idx1;
  logic [IDX_W-1:0]  w_idx2;

  // Range check is done one bit wider than the address so that a DEPTH of
  // exactly 2**ADDR_W still compares correctly. The array is indexed only
  // with the low bits, which is safe because out-of-range words are gated.
  assign w_inRange1 = ({1'b0, i_addr1} < DEPTH_L);
  assign w_inRange2 = ({1'b0, i_addr2} < DEPTH_L);
  assign w_idx1     = i_addr1[IDX_W-1:0];
  assign w_idx2     = i_addr2[IDX_W-1:0];

  // Write ports. Side 2 is applied first and side 1 second, so where both
  // sides enable the same byte of the same word the later side-1 update is
  // the one that lands.
  always_ff @(posedge clk) begin
    if (i_we2 && w_inRange2) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be2[b]) begin
          r_mem[w_idx2][b*8 +: 8] <= i_wdata2[b*8 +: 8];
        end
      end
    end
    if (i_we1 && w_inRange1) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be1[b]) begin
          r_mem[w_idx1][b*8 +: 8] <= i_wdata1[b*8 +: 8];
        end
      end
    end
  end

  // Read ports. The array is sampled at the same edge a write may land, so
  // a reader on the other side sees the word as it was before that write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      if (i_re1) begin
        r_rdata1 <= w_inRange1 ? r_mem[w_idx1] : '0;
      end
      if (i_re2) begin
        r_rdata2 <= w_inRange2 ? r_mem[w_idx2] : '0;
      end
    end
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/tag_nios_dp_onchip_ram.sv
// ---------------------------------------------------------------------------
// tag_nios_dp_onchip_ram
// True-dual-port, single-clock Avalon-MM on-chip RAM. s1 serves the CPU data
// master, s2 serves a DMA or custom master. Optional zero-fill after reset.
//
// Ports (N = 1, 2):
//   clk, reset          : system clock, synchronous active-high reset
//   reset_req           : stall new accesses on both ports while high
//   sN_address          : word address
//   sN_chipselect       : slave select
//   sN_read / sN_write  : strobes; both high means write only
//   sN_byteenable       : write byte lanes
//   sN_writedata        : write data
//   sN_readdata         : read data, valid with sN_readdatavalid
//   sN_readdatavalid    : one-cycle read-return strobe
//   sN_waitrequest      : access not accepted this cycle
//   clr_busy            : zero-fill sequencer active
// ---------------------------------------------------------------------------
module tag_nios_dp_onchip_ram
  import tag_nios_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 13312,
  parameter int    ADDR_W         = 14,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  output logic                  clr_busy
);

  // Reject configurations the datapath cannot represent.
  if ((DATA_W % 8) != 0) begin : gBadDataWidth
    $error("DATA_W must be a multiple of 8");
  end
  if (ADDR_W < clog2(DEPTH)) begin : gBadAddrWidth
    $error("ADDR_W too narrow for DEPTH");
  end

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  ramState_e          r_state;
  ramState_e          w_nextState;
  logic [ADDR_W-1:0]  r_clrAddr;
  logic               w_clrActive;
  logic               w_clrLast;
  logic               w_wait;
  logic               w_acc1;
  logic               w_acc2;
  logic               w_wr1;
  logic               w_wr2;
  logic               w_rd1;
  logic               w_rd2;
  logic               w_coreWe1;
  logic [ADDR_W-1:0]  w_coreAddr1;
  logic [DATA_W/8-1:0] w_coreBe1;
  logic [DATA_W-1:0]  w_coreWdata1;
  logic [DATA_W-1:0]  w_coreQ1;
  logic [DATA_W-1:0]  w_coreQ2;

  // State register. Reset always restarts the zero-fill when it is enabled,
  // even if it arrives halfway through a previous fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Zero-fill address counter: one word per cycle while clearing, wrapping
  // back to 0 after the last word so a later reset starts from a clean value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clrAddr <= '0;
    end else if (w_clrActive) begin
      r_clrAddr <= w_clrLast ? '0 : r_clrAddr + ADDR_W'(1);
    end
  end

  assign w_clrLast = (r_clrAddr == CLR_LAST);

  // Next-state logic: stay in CLEAR writing zeros until the last word has
  // been written, then hand the RAM over to the masters.
  always_comb begin
    w_nextState = r_state;
    w_clrActive = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clrActive = 1'b1;
        if (w_clrLast) begin
          w_nextState = ST_READY;
        end
      end
      ST_READY: begin
        w_nextState = ST_READY;
      end
      default: begin
        w_nextState = ST_READY;
      end
    endcase
  end

  // Waitrequest depends only on the FSM and reset_req, never on a master's
  // own strobes, so there is no combinational loop through the interconnect.
  assign w_wait         = (r_state == ST_CLEAR) | reset_req;
  assign s1_waitrequest = w_wait;
  assign s2_waitrequest = w_wait;
  assign clr_busy       = (r_state == ST_CLEAR);

  // Acceptance and decode. A cycle with both strobes is a pure write.
  assign w_acc1 = s1_chipselect & (s1_read | s1_write) & ~w_wait;
  assign w_acc2 = s2_chipselect & (s2_read | s2_write) & ~w_wait;
  assign w_wr1  = w_acc1 & s1_write;
  assign w_wr2  = w_acc2 & s2_write;
  assign w_rd1  = w_acc1 & s1_read & ~s1_write;
  assign w_rd2  = w_acc2 & s2_read & ~s2_write;

  // The zero-fill borrows the s1 write port; s1 cannot be accepted while
  // clearing, so the override never discards a master write.
  assign w_coreWe1    = w_clrActive | w_wr1;
  assign w_coreAddr1  = w_clrActive ? r_clrAddr : s1_address;
  assign w_coreBe1    = w_clrActive ? '1 : s1_byteenable;
  assign w_coreWdata1 = w_clrActive ? '0 : s1_writedata;

  tag_nios_dp_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) uCore (
    .clk      (clk),
    .reset    (reset),
    .i_we1    (w_coreWe1),
    .i_re1    (w_rd1),
    .i_addr1  (w_coreAddr1),
    .i_be1    (w_coreBe1),
    .i_wdata1 (w_coreWdata1),
    .o_rdata1 (w_coreQ1),
    .i_we2    (w_wr2),
    .i_re2    (w_rd2),
    .i_addr2  (s2_address),
    .i_be2    (s2_byteenable),
    .i_wdata2 (s2_writedata),
    .o_rdata2 (w_coreQ2)
  );

  if (READ_LATENCY == LAT_UNREG) begin : gLatUnreg
    logic r_vld1;
    logic r_vld2;

    // Single-cycle return: the RAM read register already holds the data and
    // only updates on accepted reads, so readdata holds between returns.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld1 <= 1'b0;
        r_vld2 <= 1'b0;
      end else begin
        r_vld1 <= w_rd1;
        r_vld2 <= w_rd2;
      end
    end

    assign s1_readdata      = w_coreQ1;
    assign s2_readdata      = w_coreQ2;
    assign s1_readdatavalid = r_vld1;
    assign s2_readdatavalid = r_vld2;
  end else if (READ_LATENCY == LAT_REG) begin : gLatReg
    logic              r_vld1a;
    logic              r_vld1b;
    logic              r_vld2a;
    logic              r_vld2b;
    logic [DATA_W-1:0] r_out1;
    logic [DATA_W-1:0] r_out2;

    // Two-cycle return: the output register captures the RAM word only on
    // the cycle it is valid, so it holds its value between returns and a
    // reset clears both the data and any read still in the pipe.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld1a <= 1'b0;
        r_vld1b <= 1'b0;
        r_vld2a <= 1'b0;
        r_vld2b <= 1'b0;
        r_out1  <= '0;
        r_out2  <= '0;
      end else begin
        r_vld1a <= w_rd1;
        r_vld1b <= r_vld1a;
        r_vld2a <= w_rd2;
        r_vld2b <= r_vld2a;
        if (r_vld1a) begin
          r_out1 <= w_coreQ1;
        end
        if (r_vld2a) begin
          r_out2 <= w_coreQ2;
        end
      end
    end

    assign s1_readdata      = r_out1;
    assign s2_readdata      = r_out2;
    assign s1_readdatavalid = r_vld1b;
    assign s2_readdatavalid = r_vld2b;
  end else begin : gBadLatency
    $error("READ_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_tag_nios_dp_onchip_ram.sv
// ---------------------------------------------------------------------------
// tb_tag_nios_dp_onchip_ram
// Two RAM instances share every input: A has read latency 1, B has read
// latency 2; both are 16 words deep with a 5-bit address and zero-fill on
// reset. A reference memory predicts read data; each accepted read pushes
// its expected word and return cycle onto a per-port queue, and a monitor
// pops and compares whenever a return is due or a DUT signals one.
// ---------------------------------------------------------------------------
module tb_tag_nios_dp_onchip_ram;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 5;
  localparam int BW  = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } expItem_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          resetReq = 1'b0;
  logic [AW-1:0] s1Address = '0;
  logic          s1Cs = 1'b0;
  logic          s1Rd = 1'b0;
  logic          s1Wr = 1'b0;
  logic [BW-1:0] s1Be = '0;
  logic [DW-1:0] s1Wd = '0;
  logic [AW-1:0] s2Address = '0;
  logic          s2Cs = 1'b0;
  logic          s2Rd = 1'b0;
  logic          s2Wr = 1'b0;
  logic [BW-1:0] s2Be = '0;
  logic [DW-1:0] s2Wd = '0;

  logic [DW-1:0] aS1Rdata, aS2Rdata, bS1Rdata, bS2Rdata;
  logic          aS1Valid, aS2Valid, bS1Valid, bS2Valid;
  logic          aS1Wait, aS2Wait, bS1Wait, bS2Wait;
  logic          aBusy, bBusy;

  int            cycle = 0;
  int            vectorCount = 0;
  int            missCount = 0;
  logic [DW-1:0] model [DEP];
  expItem_t      expQ [4][$];
  logic [3:0]    monValid;
  logic [DW-1:0] monData [4];
  logic          monExp;

  tag_nios_dp_onchip_ram #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dutA (
    .clk(clk), .reset(reset), .reset_req(resetReq),
    .s1_address(s1Address), .s1_chipselect(s1Cs), .s1_read(s1Rd), .s1_write(s1Wr),
    .s1_byteenable(s1Be), .s1_writedata(s1Wd), .s1_readdata(aS1Rdata),
    .s1_readdatavalid(aS1Valid), .s1_waitrequest(aS1Wait),
    .s2_address(s2Address), .s2_chipselect(s2Cs), .s2_read(s2Rd), .s2_write(s2Wr),
    .s2_byteenable(s2Be), .s2_writedata(s2Wd), .s2_readdata(aS2Rdata),
    .s2_readdatavalid(aS2Valid), .s2_waitrequest(aS2Wait),
    .clr_busy(aBusy)
  );

  tag_nios_dp_onchip_ram #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dutB (
    .clk(clk), .reset(reset), .reset_req(resetReq),
    .s1_address(s1Address), .s1_chipselect(s1Cs), .s1_read(s1Rd), .s1_write(s1Wr),
    .s1_byteenable(s1Be), .s1_writedata(s1Wd), .s1_readdata(bS1Rdata),
    .s1_readdatavalid(bS1Valid), .s1_waitrequest(bS1Wait),
    .s2_address(s2Address), .s2_chipselect(s2Cs), .s2_read(s2Rd), .s2_write(s2Wr),
    .s2_byteenable(s2Be), .s2_writedata(s2Wd), .s2_readdata(bS2Rdata),
    .s2_readdatavalid(bS2Valid), .s2_waitrequest(bS2Wait),
    .clr_busy(bBusy)
  );

  // Free-running clock and an edge counter used to time read returns.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic string portTag(input int i);
    case (i)
      0:       return "A.s1";
      1:       return "A.s2";
      2:       return "B.s1";
      default: return "B.s2";
    endcase
  endfunction

  // Queue an expected read return for both instances: A one edge after
  // acceptance, B two edges after.
  task automatic pushRead(input int port, input int addr);
    expItem_t item;
    if (addr < DEP) item.data = model[addr];
    else            item.data = '0;
    item.due = cycle + 1;
    expQ[port].push_back(item);
    item.due = cycle + 2;
    expQ[port + 2].push_back(item);
  endtask

  task automatic modelWrite(input int addr, input logic [BW-1:0] be, input logic [DW-1:0] data);
    if (addr < DEP) begin
      for (int b = 0; b < BW; b++) begin
        if (be[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  // Drive one cycle of stimulus on both ports. With rq high the RAM must
  // stall, so nothing is expected; otherwise reads are predicted from the
  // memory as it was before this cycle's writes, then writes are applied
  // s2 first and s1 second so s1 wins shared bytes.
  task automatic applyStimulus(input logic rq,
                               input logic r1, input logic w1, input int a1,
                               input logic [BW-1:0] be1, input logic [DW-1:0] d1,
                               input logic r2, input logic w2, input int a2,
                               input logic [BW-1:0] be2, input logic [DW-1:0] d2);
    @(negedge clk);
    resetReq  = rq;
    s1Cs      = r1 | w1;
    s1Rd      = r1;
    s1Wr      = w1;
    s1Address = AW'(a1);
    s1Be      = be1;
    s1Wd      = d1;
    s2Cs      = r2 | w2;
    s2Rd      = r2;
    s2Wr      = w2;
    s2Address = AW'(a2);
    s2Be      = be2;
    s2Wd      = d2;
    #1;
    if (r1 | w1 | r2 | w2) begin
      checkOutput(rq ? "waitHeld" : "waitFree",
                  {28'd0, aS1Wait, aS2Wait, bS1Wait, bS2Wait}, rq ? 32'hF : 32'h0);
    end
    if (!rq) begin
      if (r1 && !w1) pushRead(0, a1);
      if (r2 && !w2) pushRead(1, a2);
      if (w2) modelWrite(a2, be2, d2);
      if (w1) modelWrite(a1, be1, d1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic s1Write(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    applyStimulus(0, 0, 1, a, be, d, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic s1Read(input int a);
    applyStimulus(0, 1, 0, a, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic s2Read(input int a);
    applyStimulus(0, 0, 0, 0, 4'h0, 32'h0, 1, 0, a, 4'h0, 32'h0);
  endtask

  // Hold reset for two edges, check the reset state, then release.
  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    resetReq = 1'b0;
    s1Cs = 1'b0; s1Rd = 1'b0; s1Wr = 1'b0;
    s2Cs = 1'b0; s2Rd = 1'b0; s2Wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstValid", {28'd0, aS1Valid, aS2Valid, bS1Valid, bS2Valid}, 32'h0);
    checkOutput("rstRdataA1", aS1Rdata, 32'h0);
    checkOutput("rstRdataA2", aS2Rdata, 32'h0);
    checkOutput("rstRdataB1", bS1Rdata, 32'h0);
    checkOutput("rstRdataB2", bS2Rdata, 32'h0);
    checkOutput("rstBusy", {30'd0, aBusy, bBusy}, 32'h3);
    checkOutput("rstWait", {28'd0, aS1Wait, aS2Wait, bS1Wait, bS2Wait}, 32'hF);
    for (int i = 0; i < DEP; i++) model[i] = '0;
    reset = 1'b0;
  endtask

  // Count the cycles, starting at reset release, during which the fill is
  // reported busy and both waitrequests are high on both instances.
  task automatic measureClear(input string tag);
    int busyA, busyB, waitAll;
    busyA = 0; busyB = 0; waitAll = 0;
    for (int n = 0; n < 64; n++) begin
      if (aBusy === 1'b1) busyA++;
      if (bBusy === 1'b1) busyB++;
      if ({aS1Wait, aS2Wait, bS1Wait, bS2Wait} === 4'hF) waitAll++;
      if ((aBusy !== 1'b1) && (bBusy !== 1'b1) &&
          ({aS1Wait, aS2Wait, bS1Wait, bS2Wait} === 4'h0)) break;
      @(negedge clk);
    end
    checkOutput({tag, " busyA"}, busyA, DEP);
    checkOutput({tag, " busyB"}, busyB, DEP);
    checkOutput({tag, " wait"}, waitAll, DEP);
  endtask

  // Return monitor: any cycle where a return is due or a DUT raises valid
  // is a comparison; due returns are then checked for data and retired.
  always @(negedge clk) begin
    monValid   = {bS2Valid, bS1Valid, aS2Valid, aS1Valid};
    monData[0] = aS1Rdata;
    monData[1] = aS2Rdata;
    monData[2] = bS1Rdata;
    monData[3] = bS2Rdata;
    for (int i = 0; i < 4; i++) begin
      monExp = 1'b0;
      if (expQ[i].size() > 0) monExp = (expQ[i][0].due == cycle);
      if ((monValid[i] === 1'b1) || monExp) begin
        checkOutput({portTag(i), " valid"}, {31'd0, monValid[i]}, {31'd0, monExp});
        if (monExp) begin
          if (monValid[i] === 1'b1) checkOutput({portTag(i), " data"}, monData[i], expQ[i][0].data);
          void'(expQ[i].pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          r1, w1, r2, w2;
    logic [BW-1:0] be1, be2;
    logic [DW-1:0] d1, d2;
    int            a1, a2, pending;

    // Zero-fill after power-up, then every word reads back as zero.
    doReset();
    measureClear("clear");
    for (int i = 0; i < DEP; i++) begin
      applyStimulus(0, 1, 0, i, 4'h0, 32'h0, 1, 0, DEP - 1 - i, 4'h0, 32'h0);
    end
    idle(3);

    // Byte-lane merge on a single port.
    s1Write(5, 4'b1111, 32'hAABBCCDD);
    s1Write(5, 4'b0101, 32'h11223344);
    s1Read(5);
    idle(3);

    // Back-to-back reads on s2 must return back-to-back, in order.
    s1Write(1, 4'hF, 32'h0101_0101);
    s1Write(2, 4'hF, 32'h0202_0202);
    s1Write(3, 4'hF, 32'h0303_0303);
    s2Read(1);
    s2Read(2);
    s2Read(3);
    idle(4);

    // Cross-port write collision on one word. The upper byte is preloaded so
    // the untouched lane is recognisable in the merged result.
    s1Write(7, 4'hF, 32'h12AB_CDEF);
    applyStimulus(0, 0, 1, 7, 4'b0011, 32'h0000_FFFF, 0, 1, 7, 4'b0110, 32'h1234_5678);
    s1Read(7);
    idle(3);

    // Cross-port read during write: s2 sees the old word, then the new one.
    s1Write(8, 4'hF, 32'hCAFE_F00D);
    applyStimulus(0, 0, 1, 8, 4'hF, 32'h0102_0304, 1, 0, 8, 4'h0, 32'h0);
    s2Read(8);
    idle(3);

    // Read and write together is a write only.
    applyStimulus(0, 1, 1, 10, 4'hF, 32'h5A5A_5A5A, 0, 0, 0, 4'h0, 32'h0);
    idle(3);
    s1Read(10);
    idle(3);

    // Out-of-range: write dropped without aliasing, reads return zero.
    s1Write(4, 4'hF, 32'h4444_4444);
    s1Write(20, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 4, 4'h0, 32'h0, 1, 0, 20, 4'h0, 32'h0);
    s2Read(31);
    idle(3);

    // reset_req stall: a read in flight still returns, the held accesses
    // stall for three cycles and are taken once reset_req drops.
    s2Read(3);
    repeat (3) applyStimulus(1, 1, 0, 4, 4'h0, 32'h0, 0, 1, 9, 4'hF, 32'h9999_0000);
    applyStimulus(0, 1, 0, 4, 4'h0, 32'h0, 0, 1, 9, 4'hF, 32'h9999_0000);
    idle(3);
    s2Read(9);
    idle(3);

    // Mixed random traffic on both ports, including out-of-range words.
    for (int n = 0; n < 200; n++) begin
      r1 = 1'($urandom_range(0, 1));
      w1 = ($urandom_range(0, 2) == 0);
      a1 = int'($urandom_range(0, 19));
      be1 = 4'($urandom);
      d1 = $urandom;
      r2 = 1'($urandom_range(0, 1));
      w2 = ($urandom_range(0, 2) == 0);
      a2 = int'($urandom_range(0, 19));
      be2 = 4'($urandom);
      d2 = $urandom;
      applyStimulus(0, r1, w1, a1, be1, d1, r2, w2, a2, be2, d2);
    end
    idle(4);

    // A reset landing before B's two-cycle return must flush it; A's
    // single-cycle return completes before reset takes effect.
    s2Read(5);
    void'(expQ[3].pop_back());
    doReset();
    repeat (5) @(negedge clk);
    doReset();
    measureClear("restart");
    for (int i = 0; i < DEP; i++) begin
      applyStimulus(0, 1, 0, i, 4'h0, 32'h0, 1, 0, i, 4'h0, 32'h0);
    end
    idle(4);

    // Every expected return must have been retired.
    for (int n = 0; n < 20; n++) begin
      pending = expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size();
      if (pending == 0) break;
      @(negedge clk);
    end
    pending = expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size();
    checkOutput("drain", pending, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
